sdram_frame_scheduler: RTL

//  Shares the single-port full-page SDRAM controller between the camera write path and the display read path.

---
 rtl/sdram_frame_scheduler_if.sv | 34 +++
 rtl/sdram_frame_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sdram_frame_scheduler_if.sv
// Bus bundle between the frame scheduler, the camera/display FWFT FIFOs and the
// SDRAM controller's fpga-side port. The master modport is the scheduler side.
interface sdram_frame_scheduler_if #(
    parameter int unsigned CNT_W = 11
);
    logic [CNT_W-1:0] wr_fifo_level;
    logic [15:0]      wr_fifo_dout;
    logic             wr_fifo_rd_en;
    logic [CNT_W-1:0] rd_fifo_free;
    logic             rd_fifo_wr_en;
    logic [15:0]      rd_fifo_din;
    logic             ctl_ready;
    logic             ctl_rw;
    logic             ctl_rw_en;
    logic [14:0]      ctl_addr;
    logic [15:0]      ctl_wdata;
    logic             ctl_wvalid;
    logic [15:0]      ctl_rdata;
    logic             ctl_rvalid;

    modport master (
        input  wr_fifo_level, wr_fifo_dout, rd_fifo_free,
        input  ctl_ready, ctl_wvalid, ctl_rdata, ctl_rvalid,
        output wr_fifo_rd_en, rd_fifo_wr_en, rd_fifo_din,
        output ctl_rw, ctl_rw_en, ctl_addr, ctl_wdata
    );

    modport slave (
        output wr_fifo_level, wr_fifo_dout, rd_fifo_free,
        output ctl_ready, ctl_wvalid, ctl_rdata, ctl_rvalid,
        input  wr_fifo_rd_en, rd_fifo_wr_en, rd_fifo_din,
        input  ctl_rw, ctl_rw_en, ctl_addr, ctl_wdata
    );
endinterface

// File: rtl/sdram_frame_scheduler.sv
// Arbitrates one full-page SDRAM burst at a time between the camera write path and
// the display read path, keeping a wrapping page pointer per path.
module sdram_frame_scheduler #(
    parameter int unsigned BURST       = 512,
    parameter int unsigned CNT_W       = 11,
    parameter int unsigned FRAME_PAGES = 600,
    parameter int unsigned BASE_PAGE   = 0,
    parameter int unsigned RD_URGENT   = 1536
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_frame_sync,
    input  logic                            rd_frame_sync,
    sdram_frame_scheduler_if.master         bus,
    output logic                            busy
);
    localparam int unsigned PTR_W = $clog2(FRAME_PAGES);
    localparam int unsigned ADDR_W = 15;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] REQ        = 2'd1;
    localparam logic [1:0] WAIT_START = 2'd2;
    localparam logic [1:0] WAIT_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              last_grant_q, last_grant_d;
    logic              ctl_rw_q, ctl_rw_d;
    logic              ctl_rw_en_q, ctl_rw_en_d;
    logic [ADDR_W-1:0] ctl_addr_q, ctl_addr_d;
    logic              busy_q, busy_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;

    logic wr_ok, rd_ok, urgent, grant_rd;
    logic wr_sync_any, rd_sync_any;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FRAME_PAGES - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] page_addr(input logic [PTR_W-1:0] p);
        return ADDR_W'(BASE_PAGE + 32'(p));
    endfunction

    assign wr_ok  = bus.wr_fifo_level >= CNT_W'(BURST);
    assign rd_ok  = bus.rd_fifo_free  >= CNT_W'(BURST);
    assign urgent = bus.rd_fifo_free  >= CNT_W'(RD_URGENT);

    assign wr_sync_any = wr_pend_q | wr_frame_sync;
    assign rd_sync_any = rd_pend_q | rd_frame_sync;

    // Next-state, pointer and registered-output logic
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        last_grant_d = last_grant_q;
        ctl_rw_d     = ctl_rw_q;
        ctl_rw_en_d  = 1'b0;
        ctl_addr_d   = ctl_addr_q;
        busy_d       = busy_q;
        wr_pend_d    = wr_pend_q;
        rd_pend_d    = rd_pend_q;
        grant_rd     = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_frame_sync) wr_ptr_d = '0;
                if (rd_frame_sync) rd_ptr_d = '0;
                if (bus.ctl_ready && (wr_ok || rd_ok)) begin
                    if (urgent && rd_ok)     grant_rd = 1'b1;
                    else if (wr_ok && rd_ok) grant_rd = ~last_grant_q;
                    else                     grant_rd = rd_ok;
                    // A sync arriving with the grant still restarts the frame at page 0
                    ctl_rw_d    = grant_rd;
                    ctl_addr_d  = grant_rd ? page_addr(rd_frame_sync ? '0 : rd_ptr_q)
                                           : page_addr(wr_frame_sync ? '0 : wr_ptr_q);
                    ctl_rw_en_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (wr_frame_sync) wr_ptr_d = '0;
                if (rd_frame_sync) rd_ptr_d = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                wr_pend_d = wr_sync_any;
                rd_pend_d = rd_sync_any;
                if (!bus.ctl_ready) state_d = WAIT_DONE;
            end
            default: begin
                wr_pend_d = wr_sync_any;
                rd_pend_d = rd_sync_any;
                if (bus.ctl_ready) begin
                    // Pending syncs win over the post-burst increment
                    if (ctl_rw_q) begin
                        rd_ptr_d = rd_sync_any ? '0 : next_ptr(rd_ptr_q);
                        if (wr_sync_any) wr_ptr_d = '0;
                    end else begin
                        wr_ptr_d = wr_sync_any ? '0 : next_ptr(wr_ptr_q);
                        if (rd_sync_any) rd_ptr_d = '0;
                    end
                    wr_pend_d    = 1'b0;
                    rd_pend_d    = 1'b0;
                    last_grant_d = ctl_rw_q;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_grant_q <= 1'b1;
            ctl_rw_q     <= 1'b0;
            ctl_rw_en_q  <= 1'b0;
            ctl_addr_q   <= '0;
            busy_q       <= 1'b0;
            wr_pend_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_grant_q <= last_grant_d;
            ctl_rw_q     <= ctl_rw_d;
            ctl_rw_en_q  <= ctl_rw_en_d;
            ctl_addr_q   <= ctl_addr_d;
            busy_q       <= busy_d;
            wr_pend_q    <= wr_pend_d;
            rd_pend_q    <= rd_pend_d;
        end
    end

    assign bus.ctl_rw    = ctl_rw_q;
    assign bus.ctl_rw_en = ctl_rw_en_q;
    assign bus.ctl_addr  = ctl_addr_q;
    assign busy          = busy_q;

    // Zero-latency data steering between the FIFOs and the controller
    assign bus.wr_fifo_rd_en = bus.ctl_wvalid & ~ctl_rw_q & busy_q;
    assign bus.ctl_wdata     = bus.wr_fifo_dout;
    assign bus.rd_fifo_wr_en = bus.ctl_rvalid & ctl_rw_q & busy_q;
    assign bus.rd_fifo_din   = bus.ctl_rdata;
endmodule
